// File: rtl/max_finder.sv
// max_finder: sequential arg-max over NEURONS_NUM unsigned neuron outputs.
// Latency: result valid NEURONS_NUM-1 edges after the capture edge (one element per edge).
// Backpressure: none; a strobe arriving while a scan is running is discarded and flagged on o_drop.
//
// Ports:
//   clk, reset         - single clock, asynchronous active-high reset
//   i_data_in_valid    - one-cycle strobe, i_data_in is sampled only on the accepting edge
//   i_data_in          - packed neuron outputs, neuron k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_data_out_valid   - one-cycle pulse, o_max_index/o_max_value carry a new result
//   o_max_index        - index of the largest element (lowest index wins ties)
//   o_max_value        - value of the largest element
//   o_busy             - high while a scan is in progress
//   o_drop             - one-cycle pulse, a strobe was discarded because a scan was running
module max_finder #(
  parameter int NEURONS_NUM = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_data_in_valid,
  input  logic [NEURONS_NUM*DATA_WIDTH-1:0] i_data_in,
  output logic                              o_data_out_valid,
  output logic [INDEX_WIDTH-1:0]            o_max_index,
  output logic [DATA_WIDTH-1:0]             o_max_value,
  output logic                              o_busy,
  output logic                              o_drop
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NEURONS_NUM - 1);

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_buf [NEURONS_NUM];
  logic [DATA_WIDTH-1:0]  r_max;
  logic [INDEX_WIDTH-1:0] r_idx;
  logic [INDEX_WIDTH-1:0] r_count;

  logic                   w_capture;
  logic [DATA_WIDTH-1:0]  w_elem;
  logic                   w_gt;
  logic [DATA_WIDTH-1:0]  w_win_val;
  logic [INDEX_WIDTH-1:0] w_win_idx;

  assign w_capture = (r_state == IDLE) && i_data_in_valid;

  // Strictly-greater keeps the earlier (lower) index on ties.
  assign w_elem    = r_buf[r_count];
  assign w_gt      = (w_elem > r_max);
  assign w_win_val = w_gt ? w_elem  : r_max;
  assign w_win_idx = w_gt ? r_count : r_idx;

  // Busy is a pure decode of the registered state, so it drops together with
  // the valid pulse and is forced low immediately by reset.
  assign o_busy = (r_state == SCAN);

  // Snapshot buffer: contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int k = 0; k < NEURONS_NUM; k++) begin
        r_buf[k] <= i_data_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_max            <= '0;
      r_idx            <= '0;
      r_count          <= '0;
      o_data_out_valid <= 1'b0;
      o_max_index      <= '0;
      o_max_value      <= '0;
      o_drop           <= 1'b0;
    end else begin
      o_data_out_valid <= 1'b0;
      o_drop           <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_data_in_valid) begin
            // Element 0 seeds the running max; scanning resumes at element 1.
            r_max   <= i_data_in[DATA_WIDTH-1:0];
            r_idx   <= '0;
            r_count <= INDEX_WIDTH'(1);
            r_state <= SCAN;
          end
        end
        SCAN: begin
          o_drop  <= i_data_in_valid;
          r_max   <= w_win_val;
          r_idx   <= w_win_idx;
          r_count <= r_count + 1'b1;
          if (r_count == LAST_IDX) begin
            o_max_index      <= w_win_idx;
            o_max_value      <= w_win_val;
            o_data_out_valid <= 1'b1;
            r_count          <= '0;
            r_state          <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max_finder.sv
module tb_max_finder;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  logic            clk;
  logic            reset;
  logic            i_data_in_valid;
  logic [N*DW-1:0] i_data_in;
  logic            o_data_out_valid;
  logic [IW-1:0]   o_max_index;
  logic [DW-1:0]   o_max_value;
  logic            o_busy;
  logic            o_drop;

  max_finder #(.NEURONS_NUM(N), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_data_in_valid  (i_data_in_valid),
    .i_data_in        (i_data_in),
    .o_data_out_valid (o_data_out_valid),
    .o_max_index      (o_max_index),
    .o_max_value      (o_max_value),
    .o_busy           (o_busy),
    .o_drop           (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N*DW-1:0] d;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   val;
  } vec_t;

  vec_t tbl [7];

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] last_idx = '0;
  logic [DW-1:0] last_val = '0;

  function automatic logic [N*DW-1:0] pk(
      input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] a2,
      input logic [DW-1:0] a3, input logic [DW-1:0] a4, input logic [DW-1:0] a5,
      input logic [DW-1:0] a6, input logic [DW-1:0] a7, input logic [DW-1:0] a8,
      input logic [DW-1:0] a9);
    return {a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at a negedge; strobes d for one cycle and returns at the negedge after capture.
  task automatic send(input logic [N*DW-1:0] d);
    i_data_in       = d;
    i_data_in_valid = 1'b1;
    @(negedge clk);
    i_data_in_valid = 1'b0;
  endtask

  // Walks negedges until o_data_out_valid is seen (bounded); n = edges waited.
  task automatic wait_valid(input bit scramble, output int n);
    n = 0;
    while (!o_data_out_valid && n < 30) begin
      if (scramble) i_data_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n++;
    end
  endtask

  // Full transaction; returns at the negedge where the valid pulse is visible.
  task automatic run_vec(input string name, input vec_t v, input bit scramble);
    int n;
    send(v.d);
    chk({name, " busy_in_scan"}, 32'(o_busy), 32'd1);
    chk({name, " held_index"}, 32'(o_max_index), 32'(last_idx));
    chk({name, " held_value"}, 32'(o_max_value), 32'(last_val));
    wait_valid(scramble, n);
    chk({name, " latency"}, 32'(n), 32'd9);
    chk({name, " index"}, 32'(o_max_index), 32'(v.idx));
    chk({name, " value"}, 32'(o_max_value), 32'(v.val));
    chk({name, " busy_at_valid"}, 32'(o_busy), 32'd0);
    last_idx = v.idx;
    last_val = v.val;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int drops;
    int vals;
    logic [IW-1:0] got_idx;
    logic [DW-1:0] got_val;

    tbl[0] = '{pk(16'd5, 16'd3, 16'd9, 16'd1, 16'h7FFF, 16'd2, 16'd4, 16'd0, 16'd6, 16'd8), 4'd4, 16'h7FFF};
    tbl[1] = '{pk(16'h0, 16'h0100, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 4'd1, 16'h0100};
    tbl[2] = '{'0, 4'd0, 16'h0};
    tbl[3] = '{pk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFFFF), 4'd9, 16'hFFFF};
    tbl[4] = '{pk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 4'd0, 16'hFFFF};
    tbl[5] = '{pk(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10), 4'd9, 16'd10};
    tbl[6] = '{pk(16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFE), 4'd2, 16'h8000};

    // Reset state
    reset = 1'b1;
    i_data_in_valid = 1'b0;
    i_data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst valid", 32'(o_data_out_valid), 32'd0);
    chk("rst index", 32'(o_max_index), 32'd0);
    chk("rst value", 32'(o_max_value), 32'd0);
    chk("rst busy", 32'(o_busy), 32'd0);
    chk("rst drop", 32'(o_drop), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle busy", 32'(o_busy), 32'd0);

    // Table of vectors, first one right after reset release
    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i], 1'b0);
      chk($sformatf("vec%0d drop", i), 32'(o_drop), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d one_cycle", i), 32'(o_data_out_valid), 32'd0);
    end

    // Strobe 3 edges after capture is dropped; only the first vector's result appears
    i_data_in = tbl[0].d;
    i_data_in_valid = 1'b1;
    @(negedge clk);
    i_data_in_valid = 1'b0;
    drops = 0;
    vals = 0;
    got_idx = '0;
    got_val = '0;
    for (int t = 1; t <= 30; t++) begin
      if (t == 3) begin
        i_data_in = tbl[3].d;
        i_data_in_valid = 1'b1;
      end else begin
        i_data_in_valid = 1'b0;
      end
      @(negedge clk);
      if (o_drop) drops++;
      if (o_data_out_valid) begin
        vals++;
        got_idx = o_max_index;
        got_val = o_max_value;
      end
    end
    chk("drop count", 32'(drops), 32'd1);
    chk("drop valid_count", 32'(vals), 32'd1);
    chk("drop index", 32'(got_idx), 32'd4);
    chk("drop value", 32'(got_val), 32'h7FFF);
    last_idx = 4'd4;
    last_val = 16'h7FFF;

    // Strobe in the valid cycle is accepted; second result 9 edges later
    run_vec("b2b first", tbl[1], 1'b0);
    run_vec("b2b second", tbl[3], 1'b0);
    chk("b2b drop", 32'(o_drop), 32'd0);
    @(negedge clk);

    // Input changes during scan are ignored
    run_vec("scramble", tbl[0], 1'b1);
    i_data_in = '0;
    @(negedge clk);

    // Reset mid-scan aborts with no result
    send(tbl[5].d);
    repeat (4) @(negedge clk);
    chk("midrst busy_before", 32'(o_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst busy", 32'(o_busy), 32'd0);
    chk("midrst index", 32'(o_max_index), 32'd0);
    chk("midrst value", 32'(o_max_value), 32'd0);
    chk("midrst valid", 32'(o_data_out_valid), 32'd0);
    chk("midrst drop", 32'(o_drop), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    vals = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (o_data_out_valid) vals++;
    end
    chk("midrst no_valid", 32'(vals), 32'd0);
    last_idx = '0;
    last_val = '0;
    run_vec("after_rst", tbl[6], 1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_finder.md
MAX_FINDER -- requirements
Module: max_finder

Interface
REQ-001 Parameter NEURONS_NUM, default 10: number of neuron outputs on the input bus; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 16: width of each neuron output.
REQ-003 Parameter INDEX_WIDTH, default 4: width of the winner index; SHALL satisfy 2**INDEX_WIDTH >= NEURONS_NUM.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  reset is asynchronous and active-high.
REQ-006 i_data_in_valid  input  1  one-cycle strobe; upstream layer output vector valid (driven from the final layer's o_data_out_valid[0]).
REQ-007 i_data_in  input  NEURONS_NUM*DATA_WIDTH  final-layer outputs; neuron k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 o_data_out_valid  output  1  one-cycle pulse; result valid.
REQ-009 o_max_index  output  INDEX_WIDTH  index of the largest neuron output (classified digit).
REQ-010 o_max_value  output  DATA_WIDTH  value of the winning neuron output.
REQ-011 o_busy  output  1  high while a scan is in progress.
REQ-012 o_drop  output  1  one-cycle pulse; a strobe arrived while busy and was discarded.

Function
REQ-013 FSM states: IDLE, SCAN; no other states.
REQ-014 IDLE with i_data_in_valid=1 at an edge: capture whole i_data_in into an internal buffer; max_reg <= element 0; idx_reg <= 0; count <= 1; go to SCAN.
REQ-015 IDLE with i_data_in_valid=0: hold all state; o_busy=0.
REQ-016 SCAN, each edge: compare buffer element[count] against max_reg; if strictly greater, max_reg <= element, idx_reg <= count; count <= count+1.
REQ-017 Comparison SHALL be unsigned over DATA_WIDTH bits; ties keep the lower index.
REQ-018 SCAN edge where count == NEURONS_NUM-1: perform the final comparison, load o_max_index/o_max_value with the resulting winner, pulse o_data_out_valid for exactly one cycle, return to IDLE.
REQ-019 Latency: o_data_out_valid SHALL be high in the cycle following the (NEURONS_NUM-1)th edge after the capture edge (9 edges for default).
REQ-020 o_busy SHALL be 1 in every cycle the state is SCAN, 0 otherwise; it is 0 during the o_data_out_valid cycle.
REQ-021 i_data_in_valid=1 while in SCAN (including the final SCAN edge): strobe discarded, buffer untouched, o_drop pulses one cycle.
REQ-022 A strobe in the cycle o_data_out_valid is high SHALL be accepted (state already IDLE); back-to-back results spaced NEURONS_NUM-1 edges apart are supported.
REQ-023 o_max_index/o_max_value SHALL hold the last result until the next o_data_out_valid; they do not change during a scan.
REQ-024 i_data_in SHALL only be sampled at the capture edge; changes during SCAN have no effect.

Reset
REQ-025 reset=1 SHALL immediately force: state IDLE, count 0, o_data_out_valid 0, o_max_index 0, o_max_value 0, o_busy 0, o_drop 0; buffer contents don't-care.
REQ-026 reset asserted mid-scan SHALL abort the scan with no o_data_out_valid pulse at or after release.
REQ-027 First strobe after reset release SHALL be accepted normally at the next edge.

Verification
REQ-028 Default params, vector k=0..9 values {5,3,9,1,0x7FFF,2,4,0,6,8}, strobe -> after 9 edges o_data_out_valid=1 one cycle, o_max_index=4, o_max_value=0x7FFF.
REQ-029 Ties: values {0,0x0100,0,0x0100,0..0} -> o_max_index=1, o_max_value=0x0100; all-zero vector -> o_max_index=0, o_max_value=0.
REQ-030 Unsigned check: element 9 = 0xFFFF, others 0x7FFF -> o_max_index=9, o_max_value=0xFFFF.
REQ-031 Second strobe 3 edges after first -> o_drop pulses once, only one result (from first vector); strobe exactly in the valid cycle -> accepted, second result 9 edges later.
REQ-032 reset pulsed 5 edges into a scan -> all outputs 0 immediately, no valid pulse for 20 cycles after release; next strobe yields correct result.
REQ-033 i_data_in changed every cycle during SCAN -> result reflects only the captured vector.
